lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Sequencer for the 16x2 HD44780-style character LCD driven through the core's 32-bit LCD output register. It runs the power-up initialisation sequence autonomously, then accepts byte transfers (command or data) from the LSU-side I/O logic over a ready/valid handshake. For every transfer it generates the setup / EN-pulse / hold / execution-wait timing, so software never bit-bangs EN.

## Interface
Parameters (all in i_clk cycles; defaults are for 50 MHz):
- T_PWRUP, 750000, wait after reset release before the first init command (15 ms)
- T_SETUP, 4, RS/data stable before EN rises
- T_EN, 25, EN high width
- T_HOLD, 4, RS/data stable after EN falls
- T_CMD, 2000, execution wait for ordinary commands and data (40 us)
- T_CLR, 82000, execution wait for clear (0x01) and home (0x02) commands with RS=0 (1.64 ms)

Ports:
- i_clk  in  1  system clock, rising-edge
- i_reset  in  1  asynchronous, active-low reset
- i_req  in  1  transfer request (valid)
- i_rs  in  1  0 = command, 1 = data; sampled on accept
- i_data  in  8  byte to send; sampled on accept
- o_ready  out  1  block idle and initialised; a transfer is accepted on an edge where i_req && o_ready
- o_init_done  out  1  sticky high once the init sequence completes
- o_lcd  out  32  [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA; [30:11] always 0

## Operation
- States: PWRUP, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE.
- Reset (i_reset low): state PWRUP, counter cleared, o_lcd = 0, o_ready = 0, o_init_done = 0, init index = 0.
- PWRUP: o_lcd[31] = 1 from the first edge after reset release. Wait T_PWRUP cycles, then go to INIT_LOAD.
- INIT_LOAD: load the next init byte with RS=0. The order is 0x38, 0x0C, 0x01, 0x06. Go to SETUP.
- SETUP: EN=0 and RS/DATA driven, for T_SETUP cycles. Then PULSE.
- PULSE: EN=1 for T_EN cycles. Then HOLD.
- HOLD: EN=0 for T_HOLD cycles. Then EXEC.
- EXEC: EN=0. Wait T_CLR if RS=0 and DATA is 0x01 or 0x02; otherwise wait T_CMD. Exit:
  - init index < 3: increment the index, go to INIT_LOAD.
  - last init byte: set o_init_done, go to IDLE.
  - host transfer: go to IDLE.
- IDLE: o_ready = 1. On accept, capture i_rs/i_data into o_lcd[9]/[7:0] on that same edge and go to SETUP.
- RW (o_lcd[8]) is always 0; the busy flag is never read.
- RS/DATA keep their last transferred value while IDLE.
- i_req is ignored whenever o_ready = 0. No queueing.
- Asserting i_reset mid-transfer forces EN=0 immediately and restarts the full init sequence.
- Counter width is $clog2 of the largest parameter, plus 1. The counter counts down from (T-1) to 0.

## Timing
- Accept edge E: RS/DATA are valid from E.
- EN is high from edge E+T_SETUP to edge E+T_SETUP+T_EN.
- o_ready is low from E+1 and rises at edge E+T_SETUP+T_EN+T_HOLD+T_wait, where T_wait is T_CMD or T_CLR.
- Init completion time: o_init_done rises at T_PWRUP + 3×(T_SETUP+T_EN+T_HOLD+T_CMD) + (T_SETUP+T_EN+T_HOLD+T_CLR) edges after reset release. INIT_LOAD adds one cycle per byte, so add 4.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package lcd_ctrl_pkg holds:
  - the state enum;
  - o_lcd bit-position constants (ON=31, EN=10, RS=9, RW=8);
  - command constants: LCD_FUNC_SET=0x38, LCD_DISP_ON=0x0C, LCD_CLEAR=0x01, LCD_HOME=0x02, LCD_ENTRY=0x06;
  - the 4-entry init array.
- Sub-module lcd_delay_cnt: loadable down-counter with load value, load strobe and a done flag. It is shared by every timed state.

## Test plan
Parameters for the bench: T_PWRUP=20, T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD=10, T_CLR=40.
- Reset release -> o_lcd[31]=1 after one edge. EN pulses with DATA 0x38, 0x0C, 0x01, 0x06 in order, all with RS=0. o_init_done and o_ready rise at edge 126.
- After init, request RS=1, DATA=0x41 -> o_lcd[9:0]=0x241 at the accept edge. EN is high for exactly 4 cycles starting 2 edges later. o_ready returns 18 edges after accept.
- Request RS=0, DATA=0x01 -> o_ready returns 48 edges after accept. The same byte with RS=1 returns after 18.
- Hold i_req high continuously -> exactly one accept per o_ready high cycle. i_req during init is not accepted and no extra EN pulse appears.
- Assert i_reset during PULSE of a host transfer -> EN=0 and o_lcd=0 asynchronously. After release the full init sequence repeats.
- Check EN framing on every transfer: RS/DATA never change while EN=1 or within T_HOLD cycles after EN falls.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared types and constants for the HD44780 sequencer
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC,
        ST_IDLE
    } lcd_state_t;

    localparam int LCD_BIT_ON = 31;
    localparam int LCD_BIT_EN = 10;
    localparam int LCD_BIT_RS = 9;
    localparam int LCD_BIT_RW = 8;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_HOME     = 8'h02;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;

    localparam int INIT_LEN = 4;
    // Element 0 is sent first.
    localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ =
        {LCD_ENTRY, LCD_CLEAR, LCD_DISP_ON, LCD_FUNC_SET};

    // Clear and home are the only instructions with the long execution time.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME));
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// rtl/lcd_delay_cnt.sv - loadable down-counter shared by all timed states
module lcd_delay_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 init sequencer and timed byte-transfer engine
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    output logic        o_ready,
    output logic        o_init_done,
    output logic [31:0] o_lcd
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN, T_HOLD)),
                                max2(T_CMD, T_CLR));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    // PWRUP loads one short: the reset edge itself counts as its first cycle.
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 2);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);

    lcd_state_t       state;
    logic [1:0]       init_idx;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;

    lcd_delay_cnt #(.W(CNT_W)) u_delay (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // Counter is reloaded on the same edge the FSM leaves a timed state.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_PWRUP: begin
                if (!o_lcd[LCD_BIT_ON]) begin
                    cnt_load = 1'b1;
                    cnt_val  = LD_PWRUP;
                end
            end
            ST_INIT_LOAD: begin
                cnt_load = 1'b1;
                cnt_val  = LD_SETUP;
            end
            ST_SETUP: begin
                cnt_load = cnt_done;
                cnt_val  = LD_EN;
            end
            ST_PULSE: begin
                cnt_load = cnt_done;
                cnt_val  = LD_HOLD;
            end
            ST_HOLD: begin
                cnt_load = cnt_done;
                cnt_val  = needs_long_wait(o_lcd[LCD_BIT_RS], o_lcd[7:0]) ? LD_CLR : LD_CMD;
            end
            ST_IDLE: begin
                cnt_load = i_req;
                cnt_val  = LD_SETUP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_PWRUP;
            init_idx    <= '0;
            o_lcd       <= '0;
            o_ready     <= 1'b0;
            o_init_done <= 1'b0;
        end else begin
            case (state)
                ST_PWRUP: begin
                    o_lcd[LCD_BIT_ON] <= 1'b1;
                    if (o_lcd[LCD_BIT_ON] && cnt_done) begin
                        state <= ST_INIT_LOAD;
                    end
                end
                ST_INIT_LOAD: begin
                    o_lcd[LCD_BIT_RS] <= 1'b0;
                    o_lcd[7:0]        <= INIT_SEQ[init_idx];
                    state             <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (cnt_done) begin
                        o_lcd[LCD_BIT_EN] <= 1'b1;
                        state             <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_done) begin
                        o_lcd[LCD_BIT_EN] <= 1'b0;
                        state             <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_done) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_done) begin
                        if (o_init_done) begin
                            o_ready <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (init_idx != 2'(INIT_LEN - 1)) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= ST_INIT_LOAD;
                        end else begin
                            o_init_done <= 1'b1;
                            o_ready     <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (i_req) begin
                        o_lcd[LCD_BIT_RS] <= i_rs;
                        o_lcd[7:0]        <= i_data;
                        o_ready           <= 1'b0;
                        state             <= ST_SETUP;
                    end
                end
                default: state <= ST_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - self-checking bench for lcd_ctrl
module tb_lcd_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 4;
    localparam int T_HOLD  = 2;
    localparam int T_CMD   = 10;
    localparam int T_CLR   = 40;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req = 1'b0;
    logic        i_rs = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        o_ready;
    logic        o_init_done;
    logic [31:0] o_lcd;

    int checks = 0;
    int failures = 0;
    logic [8:0] got_q[$];

    lcd_ctrl #(
        .T_PWRUP (T_PWRUP),
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_rs        (i_rs),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_init_done (o_init_done),
        .o_lcd       (o_lcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int xfer_latency(input logic rs, input logic [7:0] data);
        int wait_t;
        wait_t = (!rs && (data == 8'h01 || data == 8'h02)) ? T_CLR : T_CMD;
        return T_SETUP + T_EN + T_HOLD + wait_t;
    endfunction

    // Pulse logger and EN framing monitor.
    logic       prev_en = 1'b0;
    logic [8:0] frame = '0;
    int         hold_left = 0;
    always @(negedge clk) begin
        if (!i_reset) begin
            prev_en   = 1'b0;
            hold_left = 0;
        end else begin
            chk("fixed_zero_bits", {o_lcd[30:11], o_lcd[8]}, '0);
            if (prev_en && !o_lcd[10]) hold_left = T_HOLD + 1;
            if (o_lcd[10] && !prev_en) begin
                frame = {o_lcd[9], o_lcd[7:0]};
                got_q.push_back(frame);
            end else if (o_lcd[10] || hold_left > 0) begin
                chk("en_framing", {o_lcd[9], o_lcd[7:0]}, frame);
            end
            if (hold_left > 0) hold_left--;
            prev_en = o_lcd[10];
        end
    end

    task automatic run_init();
        int n;
        int exp_n;
        int ready_seen;
        logic [8:0] exp_init [4];
        exp_init = '{9'h038, 9'h00C, 9'h001, 9'h006};
        exp_n = T_PWRUP + 3 * (T_SETUP + T_EN + T_HOLD + T_CMD)
              + (T_SETUP + T_EN + T_HOLD + T_CLR) + 4;
        got_q.delete();
        i_req = 1'b1;
        i_rs = 1'($urandom);
        i_data = 8'($urandom);
        @(negedge clk);
        i_reset = 1'b1;
        n = 0;
        ready_seen = 0;
        while (!o_init_done && n < 1000) begin
            tick();
            n++;
            if (n == 1) chk("pwrup_on", o_lcd, 32'h8000_0000);
            if (!o_init_done && o_ready) ready_seen++;
            i_data = 8'($urandom);
        end
        i_req = 1'b0;
        chk("init_done_edge", n, exp_n);
        chk("init_ready", o_ready, 1);
        chk("ready_low_during_init", ready_seen, 0);
        chk("init_pulse_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) chk("init_byte", got_q[i], exp_init[i]);
        end
        got_q.delete();
    endtask

    task automatic xfer(input logic rs, input logic [7:0] data);
        int k;
        int w;
        int en_start;
        int en_cnt;
        w = 0;
        while (!o_ready && w < 500) begin
            tick();
            w++;
        end
        chk("xfer_ready_wait", o_ready, 1);
        got_q.delete();
        i_req = 1'b1;
        i_rs = rs;
        i_data = data;
        tick();
        i_req = 1'b0;
        i_rs = 1'($urandom);
        i_data = 8'($urandom);
        chk("accept_rs_data", o_lcd[9:0], {rs, 1'b0, data});
        chk("ready_drop", o_ready, 0);
        k = 0;
        en_start = -1;
        en_cnt = 0;
        while (!o_ready && k < 500) begin
            tick();
            k++;
            if (o_lcd[10]) begin
                if (en_start < 0) en_start = k;
                en_cnt++;
            end
        end
        chk("xfer_latency", k, xfer_latency(rs, data));
        chk("en_start", en_start, T_SETUP);
        chk("en_width", en_cnt, T_EN);
        chk("xfer_pulse_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("xfer_pulse_byte", got_q[0], {rs, data});
        chk("idle_keeps_rs_data", o_lcd[9:0], {rs, 1'b0, data});
        got_q.delete();
    endtask

    initial begin
        int acc;
        int last;
        int n;
        int w;
        logic rs;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_lcd", o_lcd, 0);
        chk("reset_ready", o_ready, 0);
        chk("reset_init_done", o_init_done, 0);

        run_init();

        xfer(1'b1, 8'h41);
        xfer(1'b0, 8'h01);
        xfer(1'b1, 8'h01);
        xfer(1'b0, 8'h02);
        xfer(1'b0, 8'h80);

        // Continuous request: one accept per ready-high cycle.
        got_q.delete();
        i_req = 1'b1;
        i_rs = 1'b1;
        i_data = 8'h33;
        acc = 0;
        last = -1;
        n = 0;
        while (acc < 3 && n < 500) begin
            if (o_ready) begin
                acc++;
                if (last >= 0) chk("hold_gap", n - last, xfer_latency(1'b1, 8'h33) + 1);
                last = n;
                tick();
                chk("hold_one_accept", o_ready, 0);
            end else begin
                tick();
            end
            n++;
        end
        i_req = 1'b0;
        w = 0;
        while (!o_ready && w < 500) begin
            tick();
            w++;
        end
        chk("hold_accepts", acc, 3);
        chk("hold_pulses", got_q.size(), 3);
        got_q.delete();

        for (int i = 0; i < 10; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: d = 8'h01;
                1: d = 8'h02;
                default: d = 8'($urandom);
            endcase
            xfer(rs, d);
        end

        // Reset in the middle of an EN pulse.
        w = 0;
        while (!o_ready && w < 500) begin
            tick();
            w++;
        end
        i_req = 1'b1;
        i_rs = 1'b1;
        i_data = 8'h5A;
        tick();
        i_req = 1'b0;
        repeat (T_SETUP + 1) tick();
        chk("pre_reset_en", o_lcd[10], 1);
        i_reset = 1'b0;
        #1;
        chk("async_reset_lcd", o_lcd, 0);
        chk("async_reset_ready", o_ready, 0);
        chk("async_reset_init_done", o_init_done, 0);
        repeat (2) @(posedge clk);
        run_init();
        xfer(1'b1, 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
